uart_tx_buf: RTL and testbench

- Transmit-side counterpart of the UART receive FIFO: CPU/Wishbone-side logic pushes bytes into an internal FIFO.
- An 8N1 serializer drains the FIFO onto the `tx` line at a programmable bit period.
- Raises a one-cycle interrupt request when the last queued frame has fully left the wire, so firmware can refill.
- Sits between the user-project register block and the UART pad.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_buf_if.sv | 22 ++
 rtl/uart_tx_shifter.sv | 108 ++++++++++
 rtl/uart_tx_buf.sv | 90 +++++++++
 tb/tb_uart_tx_buf.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the buffered UART transmitter
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_DIV_W     = 16;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // A divider of zero would never produce a bit boundary; run it at one clock per bit.
    function automatic logic [UART_DIV_W-1:0] eff_div(input logic [UART_DIV_W-1:0] d);
        return (d == '0) ? UART_DIV_W'(1) : d;
    endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// rtl/uart_tx_buf_if.sv - register-side write port and FIFO status of the UART transmit buffer
interface uart_tx_buf_if #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
);
    logic                   w_en;
    logic [DATA_WIDTH-1:0]  data_in;
    logic                   full;
    logic                   empty;
    logic                   overflow;
    logic [$clog2(DEPTH):0] cnt;

    modport master (
        output w_en, data_in,
        input  full, empty, overflow, cnt
    );

    modport slave (
        input  w_en, data_in,
        output full, empty, overflow, cnt
    );
endinterface

// File: rtl/uart_tx_shifter.sv
// rtl/uart_tx_shifter.sv - frame FSM, bit-period counter and tx driver; UART_TX_PARITY_EN adds an even-parity bit
module uart_tx_shifter
    import uart_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tx_en,
    input  logic [UART_DIV_W-1:0]     clk_div,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [UART_DATA_BITS-1:0] ld_data,
    output logic                      tx,
    output logic                      busy,
    output logic                      stop_done
);

    tx_state_t                 state;
    logic [UART_DIV_W-1:0]     div_q;
    logic [UART_DIV_W-1:0]     bit_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      bit_end;
    logic                      load;
    logic [UART_DIV_W-1:0]     new_div;

    assign bit_end   = (bit_cnt == '0);
    assign stop_done = (state == STOP) && bit_end;
    // Reloading straight out of STOP keeps back-to-back frames gapless.
    assign ld_ready  = tx_en && ((state == IDLE) || stop_done);
    assign load      = ld_valid && ld_ready;
    assign new_div   = eff_div(clk_div);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= UART_IDLE_LEVEL;
            div_q   <= UART_DIV_W'(1);
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (load) begin
            state   <= START;
            tx      <= 1'b0;
            shreg   <= ld_data;
            div_q   <= new_div;
            bit_cnt <= new_div - UART_DIV_W'(1);
        end else begin
            case (state)
                IDLE: begin
                    tx <= UART_IDLE_LEVEL;
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        bit_cnt <= div_q - UART_DIV_W'(1);
                    end else begin
                        bit_cnt <= bit_cnt - UART_DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= div_q - UART_DIV_W'(1);
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= ^shreg;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - UART_DIV_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state   <= STOP;
                        tx      <= 1'b1;
                        bit_cnt <= div_q - UART_DIV_W'(1);
                    end else begin
                        bit_cnt <= bit_cnt - UART_DIV_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - UART_DIV_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= UART_IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - transmit FIFO with overflow flag and drain-complete interrupt feeding the 8N1 shifter
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_buf_if.slave          bus,
    input  logic                  tx_en,
    input  logic [UART_DIV_W-1:0] clk_div,
    output logic                  tx,
    output logic                  busy,
    output logic                  irq_request
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  push;
    logic                  pop;
    logic                  ld_ready;
    logic                  stop_done;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign push  = bus.w_en && !full;
    assign pop   = !empty && ld_ready;

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.overflow = overflow;
    assign bus.cnt      = cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            overflow    <= 1'b0;
            irq_request <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if (bus.w_en && full) begin
                overflow <= 1'b1;
            end
            // An empty FIFO at the end of a stop bit means nothing follows: the drain is complete.
            irq_request <= stop_done && empty;
        end
    end

    uart_tx_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_en     (tx_en),
        .clk_div   (clk_div),
        .ld_valid  (!empty),
        .ld_ready  (ld_ready),
        .ld_data   (mem[rd_ptr]),
        .tx        (tx),
        .busy      (busy),
        .stop_done (stop_done)
    );

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - directed self-checking bench for uart_tx_buf; honours UART_TX_PARITY_EN
module tb_uart_tx_buf;

`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk;
    logic        rst_n;
    logic        tx_en;
    logic [15:0] clk_div;
    logic        tx;
    logic        busy;
    logic        irq_request;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          irq_cnt = 0;

    uart_tx_buf_if #(.DEPTH(8), .DATA_WIDTH(8)) bus ();

    uart_tx_buf #(.DEPTH(8), .DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .tx_en       (tx_en),
        .clk_div     (clk_div),
        .tx          (tx),
        .busy        (busy),
        .irq_request (irq_request)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (irq_request === 1'b1) irq_cnt <= irq_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic write_byte(input logic [7:0] d);
        @(posedge clk); #1;
        bus.w_en = 1'b1;
        bus.data_in = d;
        @(posedge clk); #1;
        bus.w_en = 1'b0;
    endtask

    // Finds the next start bit and samples every bit in its middle.
    task automatic recv_byte(input int n, output logic [7:0] b, output int unsigned t0);
        int w = 0;
        b = 8'h00;
        @(negedge clk);
        while (tx !== 1'b0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("rx_start_seen", 32'(w < 5000), 32'd1);
        t0 = cyc;
        repeat (n / 2) @(negedge clk);
        check("rx_start_mid", 32'(tx), 32'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (n) @(negedge clk);
            b[k] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (n) @(negedge clk);
        check("rx_parity", 32'(tx), 32'(^b));
`endif
        repeat (n) @(negedge clk);
        check("rx_stop", 32'(tx), 32'd1);
    endtask

    task automatic count_tx_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
    endtask

    initial begin
        logic [7:0]  b;
        int unsigned t1;
        int unsigned t2;
        int          n;
        int          base;

        rst_n = 1'b0;
        tx_en = 1'b1;
        clk_div = 16'd4;
        bus.w_en = 1'b0;
        bus.data_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_cnt", 32'(bus.cnt), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_irq", 32'(irq_request), 32'd0);
        rst_n = 1'b1;

        // Single frame, exact per-clock waveform
        base = irq_cnt;
        write_byte(8'h55);
        @(negedge clk);
        check("t1_pre_tx", 32'(tx), 32'd1);
        check("t1_pre_cnt", 32'(bus.cnt), 32'd1);
        for (int i = 0; i < 4 * FB; i++) begin
            @(negedge clk);
            check($sformatf("t1_tx_%0d", i), 32'(tx), 32'(exp_bit(8'h55, i / 4)));
            check($sformatf("t1_busy_%0d", i), 32'(busy), 32'd1);
            check($sformatf("t1_irq_%0d", i), 32'(irq_request), 32'd0);
        end
        @(negedge clk);
        check("t1_irq_pulse", 32'(irq_request), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        @(negedge clk);
        check("t1_irq_drop", 32'(irq_request), 32'd0);
        check("t1_irq_count", 32'(irq_cnt - base), 32'd1);

        // Fill and overflow with transmission held off
        tx_en = 1'b0;
        @(posedge clk); #1;
        bus.w_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.data_in = 8'(i);
            @(posedge clk); #1;
        end
        bus.w_en = 1'b0;
        @(negedge clk);
        check("t2_full", 32'(bus.full), 32'd1);
        check("t2_cnt8", 32'(bus.cnt), 32'd8);
        check("t2_ovf_clear", 32'(bus.overflow), 32'd0);
        write_byte(8'h08);
        @(negedge clk);
        check("t2_ovf_set", 32'(bus.overflow), 32'd1);
        check("t2_cnt_hold", 32'(bus.cnt), 32'd8);
        check("t2_busy_off", 32'(busy), 32'd0);
        clk_div = 16'd3;
        @(posedge clk); #1;
        tx_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            recv_byte(3, b, t1);
            check($sformatf("t2_order_%0d", i), 32'(b), 32'(i));
        end
        count_tx_low(40, n);
        check("t2_no_extra_frame", 32'(n), 32'd0);
        check("t2_empty", 32'(bus.empty), 32'd1);

        // Back-to-back frames
        clk_div = 16'd2;
        base = irq_cnt;
        @(posedge clk); #1;
        bus.w_en = 1'b1;
        bus.data_in = 8'h41;
        @(posedge clk); #1;
        bus.data_in = 8'h42;
        @(posedge clk); #1;
        bus.w_en = 1'b0;
        check("t3_cnt_pushpop", 32'(bus.cnt), 32'd1);
        recv_byte(2, b, t1);
        check("t3_byte0", 32'(b), 32'h41);
        check("t3_no_mid_irq", 32'(irq_cnt - base), 32'd0);
        recv_byte(2, b, t2);
        check("t3_byte1", 32'(b), 32'h42);
        check("t3_gapless", 32'(t2 - t1), 32'(2 * FB));
        repeat (10) @(negedge clk);
        check("t3_irq_once", 32'(irq_cnt - base), 32'd1);
        check("t3_idle", 32'(busy), 32'd0);

        // Push on the same edge as the pop with one entry queued
        tx_en = 1'b0;
        write_byte(8'h11);
        @(posedge clk); #1;
        tx_en = 1'b1;
        bus.w_en = 1'b1;
        bus.data_in = 8'h22;
        @(posedge clk); #1;
        bus.w_en = 1'b0;
        check("t4_cnt_same", 32'(bus.cnt), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        recv_byte(2, b, t1);
        check("t4_first", 32'(b), 32'h11);
        recv_byte(2, b, t2);
        check("t4_second", 32'(b), 32'h22);
        repeat (6) @(negedge clk);

        // Reset in the middle of data bit 3
        clk_div = 16'd4;
        write_byte(8'hA5);
        repeat (20) @(negedge clk);
        check("t5_in_bit3", 32'(tx), 32'd0);
        check("t5_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_tx_async", 32'(tx), 32'd1);
        check("t5_cnt", 32'(bus.cnt), 32'd0);
        check("t5_empty", 32'(bus.empty), 32'd1);
        check("t5_overflow", 32'(bus.overflow), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        #3;
        rst_n = 1'b1;
        count_tx_low(30, n);
        check("t5_quiet_after", 32'(n), 32'd0);
        check("t5_busy_after", 32'(busy), 32'd0);

        // Divider of zero runs at one clock per bit
        clk_div = 16'd0;
        write_byte(8'h07);
        recv_byte(1, b, t1);
        check("t6_data07", 32'(b), 32'h07);
        repeat (5) @(negedge clk);
        write_byte(8'h3C);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        check("t6_frame_len", 32'(n), 32'(FB));
        check("t6_tx_idle", 32'(tx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
